// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } seq_state_t;

  // Width of one counter that must hold values up to the largest of a, b, c minus one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous clear; used for any
// asynchronous status bit entering the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies its lock output and releases a debounced
// core reset; retries on lock timeout and restarts on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int CNT_W         = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             core_reset,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] retry_count,
  output logic [1:0]       state_o
);

  localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

  logic lk_s;

  seq_state_t       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0] loss_reg, loss_next;
  logic [CNT_W-1:0] retry_reg, retry_next;
  logic             pll_rst_reg;
  logic             core_reset_reg;
  logic             ready_reg;

  sync_2ff u_lock_sync (
    .clk  (clk_sys),
    .srst (reset),
    .d    (pll_locked),
    .q    (lk_s)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    loss_next  = loss_reg;
    retry_next = retry_reg;
    case (state_reg)
      PLLRST: begin
        if (cnt_reg == RST_LAST) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT: begin
        // Lock seen on the timeout cycle wins over a retry.
        if (lk_s) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = PLLRST;
          cnt_next   = '0;
          if (retry_reg != '1) retry_next = retry_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SETTLE: begin
        if (!lk_s) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_next = PLLRST;
          cnt_next   = '0;
          if (loss_reg != '1) loss_next = loss_reg + 1'b1;
        end
      end
      default: begin
        state_next = PLLRST;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from state_next so they switch on the same edge as the state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= PLLRST;
      cnt_reg        <= '0;
      loss_reg       <= '0;
      retry_reg      <= '0;
      pll_rst_reg    <= 1'b1;
      core_reset_reg <= 1'b1;
      ready_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      loss_reg       <= loss_next;
      retry_reg      <= retry_next;
      pll_rst_reg    <= (state_next == PLLRST);
      core_reset_reg <= (state_next != RUN);
      ready_reg      <= (state_next == RUN);
    end
  end

  assign pll_rst     = pll_rst_reg;
  assign core_reset  = core_reset_reg;
  assign ready       = ready_reg;
  assign loss_count  = loss_reg;
  assign retry_count = retry_reg;
  assign state_o     = state_reg;

endmodule
